// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared access-size codes and FSM state encoding for the
//             load/store unit.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access size codes carried on req_size
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } lsu_state_t;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if
//  Brief    : Request/response handshake and word-memory port bundle of the
//             load/store unit. "slave" is the LSU view; "master" is the view
//             of the surrounding execute stage plus data memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_if;

  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  // Response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Word-addressed data memory port
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, readData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output MemRead, MemWrite, Address, writeData
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, readData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  MemRead, MemWrite, Address, writeData
  );

endinterface : lsu_if
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Brief    : Combinational lane logic: extracts and extends a load lane from
//             a memory word, and merges sub-word store data into an old word.
//             Lanes are little-endian (byte n = bits [8n+7:8n]).
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_new_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);

  logic [31:0] w_shifted;
  logic        w_sign;

  // Load path: shift the addressed lane down to bit 0, then extend
  always_comb begin
    w_shifted   = i_old_word >> {i_offset, 3'b000};
    w_sign      = 1'b0;
    o_load_data = w_shifted;
    case (i_size)
      SIZE_B: begin
        w_sign      = ~i_unsigned & w_shifted[7];
        o_load_data = {{24{w_sign}}, w_shifted[7:0]};
      end
      SIZE_H: begin
        w_sign      = ~i_unsigned & w_shifted[15];
        o_load_data = {{16{w_sign}}, w_shifted[15:0]};
      end
      default: o_load_data = w_shifted;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the old word
  always_comb begin
    o_merged_word = i_old_word;
    case (i_size)
      SIZE_B:  o_merged_word[{i_offset, 3'b000} +: 8] = i_new_data[7:0];
      SIZE_H:  o_merged_word[{i_offset[1], 4'b0000} +: 16] = i_new_data[15:0];
      default: o_merged_word = i_new_data;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : Byte/half/word load-store unit in front of a word-addressed data
//             memory. Checks alignment/range, extends loads, and performs
//             sub-word stores as read-modify-write through a WRITE state.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic  clk,
  input  logic  reset,   // asynchronous, active low
  lsu_if.slave  bus
);

  localparam logic [31:0] c_mem_limit = 32'(MEM_BYTES);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_waddr;
  logic [31:0] r_wbuf;

  logic        w_misalign;
  logic        w_err;
  logic [31:0] w_word_addr;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_mem_read;
  logic        w_mem_write;
  logic [31:0] w_address;
  logic [31:0] w_write_data;

  assign w_word_addr = {bus.req_addr[31:2], 2'b00};

  // Request error: illegal size, offset not a multiple of the size, or out of range
  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_size)
      SIZE_H:   w_misalign = bus.req_addr[0];
      SIZE_W:   w_misalign = |bus.req_addr[1:0];
      SIZE_ILL: w_misalign = 1'b1;
      default:  w_misalign = 1'b0;
    endcase
    w_err = w_misalign | (bus.req_addr >= c_mem_limit);
  end

  lsu_align u_align (
    .i_old_word    (bus.readData),
    .i_new_data    (bus.req_wdata),
    .i_size        (bus.req_size),
    .i_offset      (bus.req_addr[1:0]),
    .i_unsigned    (bus.req_unsigned),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged)
  );

  // State register; async reset also kills an in-flight WRITE strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and memory strobes; no access is ever issued while in reset
  always_comb begin
    w_next       = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_address    = '0;
    w_write_data = '0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_next = RESP;
          if (!w_err) begin
            w_address = w_word_addr;
            if (!bus.req_we) begin
              w_mem_read = 1'b1;
            end else if (bus.req_size == SIZE_W) begin
              w_mem_write  = 1'b1;
              w_write_data = bus.req_wdata;
            end else begin
              w_mem_read = 1'b1;
              w_next     = WRITE;
            end
          end
        end
      end
      WRITE: begin
        w_mem_write  = 1'b1;
        w_address    = r_waddr;
        w_write_data = r_wbuf;
        w_next       = RESP;
      end
      RESP: begin
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!reset) begin
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_address    = '0;
      w_write_data = '0;
    end
  end

  // Capture the response and the read-modify-write buffer on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_waddr <= '0;
      r_wbuf  <= '0;
    end else if (r_state == IDLE && bus.req_valid) begin
      r_err   <= w_err;
      r_rdata <= (w_err || bus.req_we) ? 32'h0 : w_load_data;
      if (!w_err && bus.req_we && bus.req_size != SIZE_W) begin
        r_waddr <= w_word_addr;
        r_wbuf  <= w_merged;
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.MemRead    = w_mem_read;
  assign bus.MemWrite   = w_mem_write;
  assign bus.Address    = w_address;
  assign bus.writeData  = w_write_data;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Self-checking bench for load_store_unit with a word memory model
//             and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  lsu_if bus ();

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];
  exp_t        sb_q[$];
  int          n_cmp;
  int          n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read port and posedge write port of the data memory
  assign bus.readData = mem[bus.Address[7:2]];
  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.Address[7:2]] <= bus.writeData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop and compare on every response handshake
  always @(negedge clk) begin
    if (reset && bus.resp_valid && bus.resp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
        check({e.tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
      end
    end
  end

  // Drive one request from posedge+1 and follow it to its response
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_rd, input int exp_wr);
    int lat;
    int rd;
    int wr;
    int both;
    bit done;
    exp_t e;
    lat = 0; rd = 0; wr = 0; both = 0; done = 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    e.tag = tag; e.rdata = exp_rdata; e.err = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    rd += int'(bus.MemRead);
    wr += int'(bus.MemWrite);
    both += int'(bus.MemRead & bus.MemWrite);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      lat++;
      rd += int'(bus.MemRead);
      wr += int'(bus.MemWrite);
      both += int'(bus.MemRead & bus.MemWrite);
      if (bus.resp_valid) done = 1;
    end
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_memread_cycles"}, 32'(rd), 32'(exp_rd));
    check({tag, "_memwrite_cycles"}, 32'(wr), 32'(exp_wr));
    if (both != 0) check({tag, "_strobe_overlap"}, 32'(both), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899AABB;
    mem[2] = 32'h11223344;
    mem[5] = 32'h55667788;
    reset            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_strobes", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
    check("rst_address", bus.Address, 32'd0);
    check("rst_wdata", bus.writeData, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    //    tag         we    size   uns   addr    wdata           rdata          err lat rd wr
    issue("lb_05",    1'b0, 2'b00, 1'b0, 32'h05, 32'h0,          32'hFFFFFFAA, 1'b0, 1, 1, 0);
    issue("lhu_06",   1'b0, 2'b01, 1'b1, 32'h06, 32'h0,          32'h00008899, 1'b0, 1, 1, 0);
    issue("lh_05",    1'b0, 2'b01, 1'b0, 32'h05, 32'h0,          32'h0,        1'b1, 1, 0, 0);
    issue("sb_09",    1'b1, 2'b00, 1'b0, 32'h09, 32'h000000EE,   32'h0,        1'b0, 2, 1, 1);
    check("sb_09_mem", mem[2], 32'h1122EE44);
    issue("sw_100",   1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678,  32'h0,        1'b1, 1, 0, 0);
    issue("sw_0c",    1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF,   32'h0,        1'b0, 1, 0, 1);
    check("sw_0c_mem", mem[3], 32'hDEADBEEF);
    issue("lw_0c",    1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,          32'hDEADBEEF, 1'b0, 1, 1, 0);
    issue("lbu_0f",   1'b0, 2'b00, 1'b1, 32'h0F, 32'h0,          32'h000000DE, 1'b0, 1, 1, 0);
    issue("ill_00",   1'b0, 2'b11, 1'b0, 32'h00, 32'h0,          32'h0,        1'b1, 1, 0, 0);
    issue("sw_0e",    1'b1, 2'b10, 1'b0, 32'h0E, 32'h0,          32'h0,        1'b1, 1, 0, 0);
    issue("sh_0e",    1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000CAFE,   32'h0,        1'b0, 2, 1, 1);
    check("sh_0e_mem", mem[3], 32'hCAFEBEEF);
    issue("lh_0e",    1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,          32'hFFFFCAFE, 1'b0, 1, 1, 0);

    // Back-pressure: response held stable while a second request waits
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_addr   = 32'h04;
    e.tag = "stall_lw"; e.rdata = 32'h8899AABB; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b1;
    e.tag = "stall_lbu"; e.rdata = 32'h000000BB; e.err = 1'b0;
    sb_q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("stall_resp_rdata", bus.resp_rdata, 32'h8899AABB);
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("stall_strobes", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
    end
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_second_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("stall_second_resp", {31'd0, bus.resp_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Reset asserted mid-WRITE of a half store: strobe dies, word unchanged
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b01;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h16;
    bus.req_wdata    = 32'h00001234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("rstw_in_write", {31'd0, bus.MemWrite}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rstw_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("rstw_memread", {31'd0, bus.MemRead}, 32'd0);
    check("rstw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rstw_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstw_address", bus.Address, 32'd0);
    check("rstw_wdata", bus.writeData, 32'd0);
    check("rstw_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    check("rstw_mem", mem[5], 32'h55667788);
    @(posedge clk);
    #1;
    issue("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0,      32'h55667788, 1'b0, 1, 1, 0);

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire
